// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle for clk_div_ctrl.
//   cfg_div   : requested half-period in clk_in cycles (0 is treated as 1)
//   cfg_valid : cfg_div is valid this cycle
//   cfg_ready : controller can accept a config this cycle
// master = configuration source, slave = clk_div_ctrl.
interface clk_div_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [CNT_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (
    output cfg_div,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_div,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller. It produces a square wave div_clk_out
// and a one-cycle tick_out strobe on each rising edge. Ratio changes and stops
// take effect only at full-period (falling-edge) boundaries, so the output
// never glitches and never emits a runt pulse.
// Ports:
//   clk_in      : system clock, rising edge
//   rst_in      : synchronous active-low reset
//   run         : level request for the divided clock to run
//   cfg         : config handshake (cfg_div / cfg_valid / cfg_ready)
//   div_clk_out : divided clock, period = 2 x active_div
//   tick_out    : one-cycle pulse coinciding with the rising div_clk_out
//   running     : high while the controller is not idle
//   active_div  : half-period currently in effect
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             run,
  clk_div_ctrl_if.slave    cfg,
  output logic             div_clk_out,
  output logic             tick_out,
  output logic             running,
  output logic [CNT_W-1:0] active_div
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow_div;
  logic [CNT_W-1:0] cfg_val;
  logic [CNT_W-1:0] nxt_shadow;
  logic             ready;
  logic             cfg_fire;
  logic             term;
  logic             fall;

  // Handshake and boundary decode
  assign ready         = (state != S_PEND);
  assign cfg.cfg_ready = ready;
  assign running       = (state != S_IDLE);
  assign cfg_fire      = cfg.cfg_valid && ready;
  assign cfg_val       = (cfg.cfg_div == '0) ? CNT_W'(1) : cfg.cfg_div;
  // active_div is never 0, so this subtraction cannot wrap
  assign term          = (cnt == active_div - CNT_W'(1));
  assign fall          = term && div_clk_out;
  // Shadow value including a config landing on this very edge
  assign nxt_shadow    = cfg_fire ? cfg_val : shadow_div;

  // State, counter and output registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= S_IDLE;
      cnt         <= '0;
      div_clk_out <= 1'b0;
      tick_out    <= 1'b0;
      active_div  <= CNT_W'(DEFAULT_DIV);
      shadow_div  <= CNT_W'(DEFAULT_DIV);
    end else begin
      tick_out <= 1'b0;
      if (state == S_IDLE) begin
        cnt         <= '0;
        div_clk_out <= 1'b0;
        // Keep shadow tracking active so a later stop never applies a stale value
        if (cfg_fire) begin
          active_div <= cfg_val;
          shadow_div <= cfg_val;
        end else begin
          shadow_div <= active_div;
        end
        if (run) begin
          state <= S_RUN;
        end
      end else begin
        // Half-period counter shared by RUN, PEND and STOP
        if (term) begin
          cnt         <= '0;
          div_clk_out <= ~div_clk_out;
          tick_out    <= ~div_clk_out;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end

        if (cfg_fire) begin
          shadow_div <= cfg_val;
        end

        if (state == S_RUN) begin
          if (!run) begin
            state <= S_STOP;
          end else if (cfg_fire) begin
            state <= S_PEND;
          end
        end else if (state == S_PEND) begin
          if (fall) begin
            active_div <= shadow_div;
            state      <= run ? S_RUN : S_IDLE;
          end
        end else begin
          // STOP: terminate at the falling boundary unless run came back
          if (fall) begin
            active_div <= nxt_shadow;
            shadow_div <= nxt_shadow;
            state      <= run ? S_RUN : S_IDLE;
          end else if (run) begin
            state <= (nxt_shadow != active_div) ? S_PEND : S_RUN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomised scoreboard bench for clk_div_ctrl. A phase-timer reference model
// predicts the outputs after every clock edge; a monitor compares on the
// falling edge of clk.
module tb_clk_div_ctrl;

  localparam int unsigned CW  = 16;
  localparam int unsigned DEF = 2;

  typedef struct packed {
    logic          dclk;
    logic          tick;
    logic          run_o;
    logic          rdy;
    logic [CW-1:0] div;
  } exp_t;

  logic          clk;
  logic          rst_in;
  logic          run;
  logic          div_clk_out;
  logic          tick_out;
  logic          running;
  logic [CW-1:0] active_div;

  clk_div_ctrl_if #(.CNT_W(CW)) cfg_if ();

  clk_div_ctrl #(.CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .run         (run),
    .cfg         (cfg_if.slave),
    .div_clk_out (div_clk_out),
    .tick_out    (tick_out),
    .running     (running),
    .active_div  (active_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // Reference model: level held for m_rem more edges, then flips
  logic m_running, m_level, m_tick, m_blocked, m_stopping, m_have_new;
  int   m_rem, m_active, m_new;

  task automatic model_edge(input logic r, input logic ru, input logic v, input int d);
    logic fire;
    logic fell;
    int   cv;
    fire = v && !(m_running && m_blocked);
    cv   = (d == 0) ? 1 : d;
    fell = 1'b0;
    m_tick = 1'b0;
    if (!r) begin
      m_running = 0; m_level = 0; m_blocked = 0; m_stopping = 0;
      m_have_new = 0; m_rem = 0; m_active = DEF; m_new = DEF;
    end else if (!m_running) begin
      if (fire) m_active = cv;
      if (ru) begin
        m_running = 1;
        m_rem     = m_active;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_level = !m_level;
        m_tick  = m_level;
        fell    = !m_level;
      end
      if (m_blocked) begin
        if (fell) begin
          m_active = m_new; m_blocked = 0; m_have_new = 0;
          if (!ru) m_running = 0;
        end
      end else if (m_stopping) begin
        if (fire) begin m_new = cv; m_have_new = 1; end
        if (fell) begin
          if (m_have_new) m_active = m_new;
          m_have_new = 0; m_stopping = 0;
          if (!ru) m_running = 0;
        end else if (ru) begin
          m_stopping = 0;
          m_blocked  = m_have_new && (m_new != m_active);
          m_have_new = m_blocked;
        end
      end else begin
        if (fire) begin m_new = cv; m_have_new = 1; end
        if (!ru) m_stopping = 1;
        else if (fire) m_blocked = 1;
      end
      if (m_rem == 0) m_rem = m_active;
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, advance one edge
  task automatic step(input logic r, input logic ru, input logic v, input int d);
    exp_t e;
    rst_in           = r;
    run              = ru;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = CW'(d);
    model_edge(r, ru, v, d);
    e.dclk  = m_level;
    e.tick  = m_tick;
    e.run_o = m_running;
    e.rdy   = !(m_running && m_blocked);
    e.div   = CW'(m_active);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {div_clk_out, tick_out, running, cfg_if.cfg_ready, active_div};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL cycle t=%0t: got clk=%b tick=%b run=%b rdy=%b div=%0d, expected clk=%b tick=%b run=%b rdy=%b div=%0d",
                    $time, a.dclk, a.tick, a.run_o, a.rdy, a.div,
                    e.dclk, e.tick, e.run_o, e.rdy, e.div);
    end
  end

  // Step with run held until the DUT reaches the requested div_clk_out level
  task automatic wait_level(input logic ru, input logic lvl, input string name);
    int n;
    n = 0;
    while (div_clk_out !== lvl && n < 40) begin
      step(1, ru, 0, 0);
      n++;
    end
    if (div_clk_out !== lvl) check(name, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (running !== 1'b0 && n < 60) begin
      step(1, 0, 0, 0);
      n++;
    end
    check(name, int'(running), 0);
  endtask

  initial begin
    int lat;
    int ticks;
    rst_in = 0; run = 0; cfg_if.cfg_valid = 0; cfg_if.cfg_div = '0;

    // Reset default
    repeat (3) step(0, 0, 0, 0);
    check("reset_div", int'(active_div), 2);
    check("reset_ready", int'(cfg_if.cfg_ready), 1);
    check("reset_running", int'(running), 0);
    step(1, 1, 0, 0);
    lat = 0;
    while (div_clk_out !== 1'b1 && lat < 20) begin
      step(1, 1, 0, 0);
      lat++;
    end
    check("start_latency", lat, 2);
    check("first_tick", int'(tick_out), 1);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0);
      ticks += int'(tick_out);
    end
    check("ticks_div2", ticks, 3);

    // Zero config maps to 1
    wait_idle("idle_after_default");
    step(1, 0, 1, 0);
    check("zero_cfg_div", int'(active_div), 1);
    step(1, 1, 0, 0);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0);
      ticks += int'(tick_out);
    end
    check("ticks_div1", ticks, 4);

    // Mid-run change 3 -> 5 issued during a high phase
    wait_idle("idle_after_div1");
    step(1, 0, 1, 3);
    step(1, 1, 0, 0);
    wait_level(1, 1, "reach_high_3");
    step(1, 1, 1, 5);
    check("pend_not_ready", int'(cfg_if.cfg_ready), 0);
    for (int i = 0; i < 30; i++) step(1, 1, 0, 0);
    check("div_now_5", int'(active_div), 5);

    // Clean stop at 4, one cycle into a high phase
    wait_idle("idle_after_change");
    step(1, 0, 1, 4);
    step(1, 1, 0, 0);
    wait_level(1, 1, "reach_high_4");
    step(1, 1, 0, 0);
    wait_idle("stop_completes");
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      ticks += int'(tick_out);
    end
    check("no_ticks_after_stop", ticks, 0);

    // Reset while high in PEND discards the shadow value
    step(1, 1, 0, 0);
    wait_level(1, 1, "reach_high_pend");
    step(1, 1, 1, 7);
    check("pend_entered", int'(cfg_if.cfg_ready), 0);
    step(0, 1, 0, 0);
    check("rst_mid_clk", int'(div_clk_out), 0);
    check("rst_mid_div", int'(active_div), 2);
    check("rst_mid_ready", int'(cfg_if.cfg_ready), 1);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);

    // Run dropped for one cycle and re-asserted
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);

    // Randomised traffic
    begin
      logic r_run;
      r_run = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 29) == 0) r_run = ~r_run;
        step(($urandom_range(0, 599) != 0), r_run,
             ($urandom_range(0, 7) == 0), int'($urandom_range(0, 5)));
      end
    end

    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
